// File: rtl/biu_pkg.sv
// Shared bus-interface-unit definitions: bus commands, owner IDs and the
// arbiter grant states.
package biu_pkg;

    typedef enum logic [1:0] {
        BUS_CMD_READ  = 2'd0,
        BUS_CMD_WRITE = 2'd1
    } bus_cmd_e;

    // Owner of an outstanding bus request; stored 1 bit wide in the owner FIFO.
    typedef enum logic {
        BIU_OWN_IF = 1'b0,
        BIU_OWN_LS = 1'b1
    } biu_own_e;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LOCK_IF = 2'd1,
        ARB_LOCK_LS = 2'd2
    } biu_arb_state_e;

endpackage

// File: rtl/biu_if.sv
// Requester and bus transaction interfaces used by the bus interface unit.
// The arbiter sits on the slave side of both requesters and masters the bus.
interface ifetch_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_vld;
    logic          req_rdy;
    logic [AW-1:0] req_pc;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_ir;

    modport master (output req_vld, req_pc, rsp_rdy, input req_rdy, rsp_vld, rsp_ir);
    modport slave  (input req_vld, req_pc, rsp_rdy, output req_rdy, rsp_vld, rsp_ir);
endinterface

interface ldst_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import biu_pkg::*;

    typedef struct packed {
        bus_cmd_e        cmd;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } req_pkt_t;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_pkt_t;

    logic     req_vld;
    logic     req_rdy;
    req_pkt_t req_pkt;
    logic     rsp_vld;
    logic     rsp_rdy;
    rsp_pkt_t rsp_pkt;

    modport master (output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
    modport slave  (input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
endinterface

interface bus_trans_if_t #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import biu_pkg::*;

    typedef struct packed {
        bus_cmd_e        cmd;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } req_pkt_t;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_pkt_t;

    logic     req_vld;
    logic     req_rdy;
    req_pkt_t req_pkt;
    logic     rsp_vld;
    logic     rsp_rdy;
    rsp_pkt_t rsp_pkt;

    modport master (output req_vld, req_pkt, rsp_rdy, input req_rdy, rsp_vld, rsp_pkt);
    modport slave  (input req_vld, req_pkt, rsp_rdy, output req_rdy, rsp_vld, rsp_pkt);
endinterface

// File: rtl/biu_own_fifo.sv
// Small in-order FIFO remembering which requester owns each outstanding bus
// request. Pushes when full and pops when empty are ignored.
module biu_own_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/biu_arb.sv
// Arbitrates instruction fetch and load/store requests onto one bus and
// routes responses back in order. Define BIU_ARB_RR_EN for round-robin.
module biu_arb
    import biu_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_if_t.slave     ifetch,
    ldst_if_t.slave       ldst,
    bus_trans_if_t.master bti
);

    localparam int CW = $clog2(OUTS_DEPTH + 1);

    biu_arb_state_e state;
    biu_arb_state_e state_nxt;
    logic           grant_ls;
    logic           idle_win_ls;
    logic           req_open;
    logic           req_hs;
    logic           rsp_open;
    logic           rsp_hs;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic [0:0]     head_bits;
    biu_own_e       head_own;
    biu_own_e       push_own;

`ifdef BIU_ARB_RR_EN
    biu_own_e last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= BIU_OWN_LS;
        end else if (req_hs) begin
            last_grant <= push_own;
        end
    end

    assign idle_win_ls = (ldst.req_vld && ifetch.req_vld) ? (last_grant == BIU_OWN_IF)
                                                          : ldst.req_vld;
`else
    assign idle_win_ls = ldst.req_vld;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request stalled by the bus locks its grant until it handshakes, so
    // the packet on the bus never changes under a pending valid.
    always_comb begin
        state_nxt = state;
        grant_ls  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                grant_ls = idle_win_ls;
                if (req_open && (idle_win_ls ? ldst.req_vld : ifetch.req_vld) && !bti.req_rdy) begin
                    state_nxt = idle_win_ls ? ARB_LOCK_LS : ARB_LOCK_IF;
                end
            end
            ARB_LOCK_IF: begin
                grant_ls = 1'b0;
                if (req_open && ifetch.req_vld && bti.req_rdy) begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_LOCK_LS: begin
                grant_ls = 1'b1;
                if (req_open && ldst.req_vld && bti.req_rdy) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    assign fifo_full  = (fifo_count == CW'(OUTS_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign req_open   = !rst && !fifo_full;
    assign push_own   = grant_ls ? BIU_OWN_LS : BIU_OWN_IF;

    assign bti.req_vld    = req_open && (grant_ls ? ldst.req_vld : ifetch.req_vld);
    assign ifetch.req_rdy = req_open && !grant_ls && bti.req_rdy;
    assign ldst.req_rdy   = req_open && grant_ls && bti.req_rdy;
    assign req_hs         = bti.req_vld && bti.req_rdy;

    always_comb begin
        bti.req_pkt.cmd  = BUS_CMD_READ;
        bti.req_pkt.addr = AW'(ifetch.req_pc);
        bti.req_pkt.data = {DW{1'b0}};
        bti.req_pkt.be   = {(DW/8){1'b0}};
        if (grant_ls) begin
            bti.req_pkt.cmd  = ldst.req_pkt.cmd;
            bti.req_pkt.addr = ldst.req_pkt.addr;
            bti.req_pkt.data = ldst.req_pkt.data;
            bti.req_pkt.be   = ldst.req_pkt.be;
        end
    end

    assign head_own = biu_own_e'(head_bits);
    assign rsp_open = !rst && !fifo_empty;

    assign ifetch.rsp_vld = rsp_open && (head_own == BIU_OWN_IF) && bti.rsp_vld;
    assign ldst.rsp_vld   = rsp_open && (head_own == BIU_OWN_LS) && bti.rsp_vld;
    assign bti.rsp_rdy    = rsp_open && ((head_own == BIU_OWN_LS) ? ldst.rsp_rdy : ifetch.rsp_rdy);
    assign rsp_hs         = bti.rsp_vld && bti.rsp_rdy;

    assign ifetch.rsp_ir     = bti.rsp_pkt.data;
    assign ldst.rsp_pkt.data = bti.rsp_pkt.data;
    assign ldst.rsp_pkt.err  = bti.rsp_pkt.err;

    biu_own_fifo #(
        .DEPTH (OUTS_DEPTH),
        .WIDTH (1)
    ) u_own_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_hs),
        .push_data (push_own),
        .pop       (rsp_hs),
        .pop_data  (head_bits),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_biu_arb.sv
// Directed bench for biu_arb: a request scoreboard and an owner model check
// every bus handshake and every routed response.
module tb_biu_arb;
    import biu_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic        ls;
        logic [31:0] addr;
        bus_cmd_e    cmd;
    } exp_req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_if_t    #(.AW(AW), .DW(DW)) if_bus ();
    ldst_if_t      #(.AW(AW), .DW(DW)) ls_bus ();
    bus_trans_if_t #(.AW(AW), .DW(DW)) bt_bus ();

    biu_arb #(
        .AW         (AW),
        .DW         (DW),
        .OUTS_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ifetch (if_bus),
        .ldst   (ls_bus),
        .bti    (bt_bus)
    );

    int       total = 0;
    int       bad   = 0;
    exp_req_t exp_q [$];
    logic     own_q [$];

    logic        s_rst, s_if_vld, s_if_rsp_rdy, s_ls_vld, s_ls_rsp_rdy, s_bus_rdy, s_rsp_vld;
    logic [31:0] s_if_pc, s_ls_addr, s_ls_data, s_rsp_data;
    bus_cmd_e    s_ls_cmd;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expectReq(input logic ls, input logic [31:0] addr, input bus_cmd_e cmd);
        exp_req_t e;
        e.ls   = ls;
        e.addr = addr;
        e.cmd  = cmd;
        exp_q.push_back(e);
    endtask

    // Compares response routing against the owner model, then matches any
    // request handshake against the next expected grant.
    task automatic sampleBus();
        logic     has;
        logic     head;
        exp_req_t e;
        if (s_rst) begin
            own_q.delete();
            return;
        end
        has  = (own_q.size() != 0);
        head = has ? own_q[0] : 1'b0;
        checkOutput("rsp_vld_if", 64'(if_bus.rsp_vld), 64'(s_rsp_vld && has && !head));
        checkOutput("rsp_vld_ls", 64'(ls_bus.rsp_vld), 64'(s_rsp_vld && has && head));
        checkOutput("rsp_rdy", 64'(bt_bus.rsp_rdy), 64'(has && (head ? s_ls_rsp_rdy : s_if_rsp_rdy)));
        if (s_rsp_vld && bt_bus.rsp_rdy && has) begin
            void'(own_q.pop_front());
            checkOutput("rsp_data", 64'(head ? ls_bus.rsp_pkt.data : if_bus.rsp_ir), 64'(s_rsp_data));
        end
        if (bt_bus.req_vld && bt_bus.req_rdy) begin
            if (exp_q.size() == 0) begin
                checkOutput("req_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("req_owner_ls", 64'(ls_bus.req_rdy), 64'(e.ls));
                checkOutput("req_owner_if", 64'(if_bus.req_rdy), 64'(!e.ls));
                checkOutput("req_addr", 64'(bt_bus.req_pkt.addr), 64'(e.addr));
                checkOutput("req_cmd", 64'(bt_bus.req_pkt.cmd), 64'(e.cmd));
                own_q.push_back(e.ls);
            end
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        rst                    = s_rst;
        if_bus.req_vld         = s_if_vld;
        if_bus.req_pc          = s_if_pc;
        if_bus.rsp_rdy         = s_if_rsp_rdy;
        ls_bus.req_vld         = s_ls_vld;
        ls_bus.req_pkt.cmd     = s_ls_cmd;
        ls_bus.req_pkt.addr    = s_ls_addr;
        ls_bus.req_pkt.data    = s_ls_data;
        ls_bus.req_pkt.be      = 4'hF;
        ls_bus.rsp_rdy         = s_ls_rsp_rdy;
        bt_bus.req_rdy         = s_bus_rdy;
        bt_bus.rsp_vld         = s_rsp_vld;
        bt_bus.rsp_pkt.data    = s_rsp_data;
        bt_bus.rsp_pkt.err     = 1'b0;
        #1;
        sampleBus();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_bti_req_vld"}, 64'(bt_bus.req_vld), 64'd0);
        checkOutput({tag, "_bti_rsp_rdy"}, 64'(bt_bus.rsp_rdy), 64'd0);
        checkOutput({tag, "_if_req_rdy"}, 64'(if_bus.req_rdy), 64'd0);
        checkOutput({tag, "_ls_req_rdy"}, 64'(ls_bus.req_rdy), 64'd0);
        checkOutput({tag, "_if_rsp_vld"}, 64'(if_bus.rsp_vld), 64'd0);
        checkOutput({tag, "_ls_rsp_vld"}, 64'(ls_bus.rsp_vld), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        s_rst        = 1'b1;
        s_if_vld     = 1'b1;
        s_if_pc      = 32'h100;
        s_if_rsp_rdy = 1'b1;
        s_ls_vld     = 1'b1;
        s_ls_cmd     = BUS_CMD_WRITE;
        s_ls_addr    = 32'h200;
        s_ls_data    = 32'hDEAD;
        s_ls_rsp_rdy = 1'b1;
        s_bus_rdy    = 1'b1;
        s_rsp_vld    = 1'b1;
        s_rsp_data   = 32'h55;

        // Reset with every input asserted.
        applyStimulus();
        applyStimulus();
        checkAllZero("reset");

        // Single fetch, zero-latency pass-through, then its response.
        s_rst     = 1'b0;
        s_ls_vld  = 1'b0;
        s_rsp_vld = 1'b0;
        expectReq(1'b0, 32'h100, BUS_CMD_READ);
        applyStimulus();
        checkOutput("fetch_req_vld", 64'(bt_bus.req_vld), 64'd1);
        checkOutput("fetch_addr", 64'(bt_bus.req_pkt.addr), 64'h100);
        checkOutput("fetch_req_rdy", 64'(if_bus.req_rdy), 64'd1);
        s_if_vld   = 1'b0;
        s_rsp_vld  = 1'b1;
        s_rsp_data = 32'h0000_0013;
        applyStimulus();
        checkOutput("fetch_rsp_ir", 64'(if_bus.rsp_ir), 64'h13);
        checkOutput("fetch_rsp_vld", 64'(if_bus.rsp_vld), 64'd1);
        s_rsp_vld = 1'b0;

        // Contention for four cycles fills the owner FIFO.
        s_if_vld = 1'b1;
        s_if_pc  = 32'h300;
        s_ls_vld = 1'b1;
`ifdef BIU_ARB_RR_EN
        expectReq(1'b1, 32'h200, BUS_CMD_WRITE);
        expectReq(1'b0, 32'h300, BUS_CMD_READ);
        expectReq(1'b1, 32'h200, BUS_CMD_WRITE);
        expectReq(1'b0, 32'h300, BUS_CMD_READ);
`else
        for (int i = 0; i < 4; i++) expectReq(1'b1, 32'h200, BUS_CMD_WRITE);
`endif
        for (int i = 0; i < 4; i++) applyStimulus();

        // Full: request held, even while a response pops in the same cycle.
        s_ls_vld = 1'b0;
        applyStimulus();
        checkOutput("full_req_vld", 64'(bt_bus.req_vld), 64'd0);
        checkOutput("full_if_req_rdy", 64'(if_bus.req_rdy), 64'd0);
        s_rsp_vld  = 1'b1;
        s_rsp_data = 32'h21;
        applyStimulus();
        checkOutput("full_pop_req_vld", 64'(bt_bus.req_vld), 64'd0);
        checkOutput("full_pop_ls_req_rdy", 64'(ls_bus.req_rdy), 64'd0);
        s_rsp_vld = 1'b0;
        expectReq(1'b0, 32'h300, BUS_CMD_READ);
        applyStimulus();
        checkOutput("after_pop_if_req_rdy", 64'(if_bus.req_rdy), 64'd1);
        s_if_vld  = 1'b0;
        s_rsp_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_rsp_data = 32'h30 + 32'(i);
            applyStimulus();
        end
        s_rsp_vld = 1'b0;

        // Stalled fetch keeps its grant while ldst joins.
        s_bus_rdy = 1'b0;
        s_if_vld  = 1'b1;
        s_if_pc   = 32'h400;
        applyStimulus();
        checkOutput("stall1_addr", 64'(bt_bus.req_pkt.addr), 64'h400);
        checkOutput("stall1_if_req_rdy", 64'(if_bus.req_rdy), 64'd0);
        s_ls_vld  = 1'b1;
        s_ls_addr = 32'h500;
        s_ls_cmd  = BUS_CMD_READ;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("stall_addr", 64'(bt_bus.req_pkt.addr), 64'h400);
            checkOutput("stall_ls_req_rdy", 64'(ls_bus.req_rdy), 64'd0);
        end
        s_bus_rdy = 1'b1;
        expectReq(1'b0, 32'h400, BUS_CMD_READ);
        applyStimulus();
        checkOutput("stall_hs_ls_req_rdy", 64'(ls_bus.req_rdy), 64'd0);
        s_if_vld = 1'b0;
        expectReq(1'b1, 32'h500, BUS_CMD_READ);
        applyStimulus();
        checkOutput("stall_next_ls_req_rdy", 64'(ls_bus.req_rdy), 64'd1);
        s_ls_vld = 1'b0;

        // Interleaved owners IF, LS, IF with in-order responses.
        s_if_vld = 1'b1;
        s_if_pc  = 32'h600;
        expectReq(1'b0, 32'h600, BUS_CMD_READ);
        applyStimulus();
        s_if_vld     = 1'b0;
        s_rsp_vld    = 1'b1;
        s_rsp_data   = 32'hA;
        s_if_rsp_rdy = 1'b0;
        applyStimulus();
        checkOutput("head_backpressure_rsp_rdy", 64'(bt_bus.rsp_rdy), 64'd0);
        s_if_rsp_rdy = 1'b1;
        applyStimulus();
        checkOutput("inorder_if_a", 64'(if_bus.rsp_ir), 64'hA);
        s_rsp_data = 32'hB;
        applyStimulus();
        checkOutput("inorder_ls_b", 64'(ls_bus.rsp_pkt.data), 64'hB);
        checkOutput("inorder_ls_b_vld", 64'(ls_bus.rsp_vld), 64'd1);
        s_rsp_data = 32'hC;
        applyStimulus();
        checkOutput("inorder_if_c", 64'(if_bus.rsp_ir), 64'hC);
        checkOutput("inorder_if_c_vld", 64'(if_bus.rsp_vld), 64'd1);
        s_rsp_vld = 1'b0;

        // Reset with two requests outstanding discards their ownership.
        s_if_vld = 1'b1;
        s_if_pc  = 32'h700;
        expectReq(1'b0, 32'h700, BUS_CMD_READ);
        applyStimulus();
        s_if_vld  = 1'b0;
        s_ls_vld  = 1'b1;
        s_ls_addr = 32'h704;
        s_ls_cmd  = BUS_CMD_WRITE;
        expectReq(1'b1, 32'h704, BUS_CMD_WRITE);
        applyStimulus();
        s_ls_vld  = 1'b0;
        s_rst     = 1'b1;
        s_if_vld  = 1'b1;
        s_rsp_vld = 1'b1;
        applyStimulus();
        checkAllZero("midrst");
        s_rst    = 1'b0;
        s_if_vld = 1'b0;
        applyStimulus();
        checkOutput("stray_rsp_rdy", 64'(bt_bus.rsp_rdy), 64'd0);
        checkOutput("stray_if_rsp_vld", 64'(if_bus.rsp_vld), 64'd0);
        checkOutput("stray_ls_rsp_vld", 64'(ls_bus.rsp_vld), 64'd0);
        s_rsp_vld = 1'b0;
        applyStimulus();

        checkOutput("all_requests_seen", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
